// File: rtl/mul7x7_seq_ctrl.sv
// ============================================================================
// Module      : mul7x7_seq_ctrl
// Description : Four-pass sequencer that forms a (2*HW)x(2*HW) unsigned
//               product by time-sharing one external HWxHW combinational
//               multiplier. Valid/ready handshakes on operand and result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul7x7_seq_ctrl #(
   parameter int HW = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*HW-1:0]   in_a,
   input  logic [2*HW-1:0]   in_b,
   output logic [HW-1:0]     mul_a,
   output logic [HW-1:0]     mul_b,
   input  logic [2*HW-1:0]   mul_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4*HW-1:0]   out_p,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_P0   = 3'd1,
      S_P1   = 3'd2,
      S_P2   = 3'd3,
      S_P3   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t              state_q;
   logic [2*HW-1:0]     opa_q;
   logic [2*HW-1:0]     opb_q;
   logic [4*HW-1:0]     acc_q;
   logic [4*HW-1:0]     acc_d;
   logic [4*HW-1:0]     out_p_q;
   logic                out_valid_q;
   logic                in_ready_q;
   logic                busy_q;
   logic [4*HW-1:0]     term;
   logic [4*HW-1:0]     mul_p_ext;

   // Zero-extend the partial product before it is weighted by a shift.
   assign mul_p_ext = {{(2*HW){1'b0}}, mul_p};

   // Operand half-select and partial-product weight for the current pass.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      term  = '0;
      case (state_q)
         S_P0: begin
            mul_a = opa_q[HW-1:0];
            mul_b = opb_q[HW-1:0];
            term  = mul_p_ext;
         end
         S_P1: begin
            mul_a = opa_q[2*HW-1:HW];
            mul_b = opb_q[HW-1:0];
            term  = mul_p_ext << HW;
         end
         S_P2: begin
            mul_a = opa_q[HW-1:0];
            mul_b = opb_q[2*HW-1:HW];
            term  = mul_p_ext << HW;
         end
         S_P3: begin
            mul_a = opa_q[2*HW-1:HW];
            mul_b = opb_q[2*HW-1:HW];
            term  = mul_p_ext << (2*HW);
         end
         default: begin
            mul_a = '0;
            mul_b = '0;
            term  = '0;
         end
      endcase
   end

   // Accumulator next value; the sum of all four passes cannot exceed 4*HW bits.
   assign acc_d = acc_q + term;

   // Sequencer state, operand capture, accumulation and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         opa_q       <= '0;
         opb_q       <= '0;
         acc_q       <= '0;
         out_p_q     <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  opa_q      <= in_a;
                  opb_q      <= in_b;
                  acc_q      <= '0;
                  state_q    <= S_P0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_P0: begin
               acc_q   <= acc_d;
               state_q <= S_P1;
            end
            S_P1: begin
               acc_q   <= acc_d;
               state_q <= S_P2;
            end
            S_P2: begin
               acc_q   <= acc_d;
               state_q <= S_P3;
            end
            S_P3: begin
               acc_q       <= acc_d;
               out_p_q     <= acc_d;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               // Result stays on out_p after consumption; only rst clears it.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign out_p     = out_p_q;
   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mul7x7_seq_ctrl.sv
// ============================================================================
// Module      : tb_mul7x7_seq_ctrl
// Description : Directed self-checking bench for mul7x7_seq_ctrl with a
//               behavioural 7x7 multiplier standing in for the shared array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul7x7_seq_ctrl;

   localparam int HW = 7;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [2*HW-1:0] in_a;
   logic [2*HW-1:0] in_b;
   logic [HW-1:0]   mul_a;
   logic [HW-1:0]   mul_b;
   logic [2*HW-1:0] mul_p;
   logic            out_valid;
   logic            out_ready;
   logic [4*HW-1:0] out_p;
   logic            busy;

   int n_checks = 0;
   int n_errors = 0;

   mul7x7_seq_ctrl #(.HW(HW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   // Behavioural shared multiplier: combinational in the same cycle.
   assign mul_p = (2*HW)'(mul_a) * (2*HW)'(mul_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, four passes, result, consume.
   task automatic run_op(input logic [13:0] a, input logic [13:0] b,
                         input logic [27:0] exp_p, input bit chk_max);
      logic [6:0] ea;
      logic [6:0] eb;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      out_ready = 1'b1;
      check_val("in_ready_c0", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ea = (k % 2 == 0) ? a[6:0] : a[13:7];
         eb = (k < 2) ? b[6:0] : b[13:7];
         check_val("busy_pass", 32'(busy), 32'd1);
         check_val("out_valid_pass", 32'(out_valid), 32'd0);
         check_val("in_ready_pass", 32'(in_ready), 32'd0);
         check_val("mul_a_pass", 32'(mul_a), 32'(ea));
         check_val("mul_b_pass", 32'(mul_b), 32'(eb));
         if (chk_max) begin
            check_val("mul_a_max", 32'(mul_a), 32'd127);
            check_val("mul_b_max", 32'(mul_b), 32'd127);
         end
         tick();
      end
      check_val("out_valid_c5", 32'(out_valid), 32'd1);
      check_val("busy_c5", 32'(busy), 32'd1);
      check_val("in_ready_c5", 32'(in_ready), 32'd0);
      check_val("out_p", 32'(out_p), 32'(exp_p));
      check_val("mul_a_done", 32'(mul_a), 32'd0);
      tick();
      check_val("out_valid_c6", 32'(out_valid), 32'd0);
      check_val("in_ready_c6", 32'(in_ready), 32'd1);
      check_val("busy_c6", 32'(busy), 32'd0);
      check_val("out_p_held", 32'(out_p), 32'(exp_p));
   endtask

   int acc_cyc [2];
   int acc_n;
   int res_n;
   logic [27:0] exp_q [2];

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_p", 32'(out_p), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_mul_a", 32'(mul_a), 32'd0);
      check_val("rst_mul_b", 32'(mul_b), 32'd0);

      // 129*3 = 387
      run_op(14'd129, 14'd3, 28'd387, 1'b0);
      // 16383*16383 = 268402689
      run_op(14'd16383, 14'd16383, 28'd268402689, 1'b1);
      // 16256*127 = 2064512 (pure cross term)
      run_op(14'h3F80, 14'h007F, 28'd2064512, 1'b0);
      // zero operand
      run_op(14'd0, 14'd12345, 28'd0, 1'b0);

      // Back-pressure: 1000*2000 = 2000000
      in_valid  = 1'b1;
      in_a      = 14'd1000;
      in_b      = 14'd2000;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check_val("bp_out_valid", 32'(out_valid), 32'd1);
      for (int k = 0; k < 10; k++) begin
         tick();
         check_val("bp_out_p_stable", 32'(out_p), 32'd2000000);
         check_val("bp_in_ready", 32'(in_ready), 32'd0);
         check_val("bp_out_valid_hold", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      check_val("bp_release_in_ready", 32'(in_ready), 32'd1);
      check_val("bp_release_out_valid", 32'(out_valid), 32'd0);

      // Reset in P2
      in_valid = 1'b1;
      in_a     = 14'd200;
      in_b     = 14'd300;
      tick();                 // P0
      in_valid = 1'b0;
      tick();                 // P1
      tick();                 // P2
      check_val("pre_rst_mul_b", 32'(mul_b), 32'(300 >> 7));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_val("mid_rst_out_p", 32'(out_p), 32'd0);
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         check_val("no_stale_valid", 32'(out_valid), 32'd0);
      end
      run_op(14'd5, 14'd7, 28'd35, 1'b0);

      // Back-to-back with in_valid held high
      exp_q[0]  = 28'd20000;   // 100*200
      exp_q[1]  = 28'd16383;   // 16383*1
      acc_n     = 0;
      res_n     = 0;
      in_valid  = 1'b1;
      in_a      = 14'd100;
      in_b      = 14'd200;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (in_valid && in_ready && acc_n < 2) begin
            acc_cyc[acc_n] = cyc;
            acc_n++;
         end
         if (out_valid && out_ready && res_n < 2) begin
            check_val("b2b_out_p", 32'(out_p), 32'(exp_q[res_n]));
            res_n++;
         end
         tick();
         if (acc_n == 1) begin
            in_a = 14'd16383;
            in_b = 14'd1;
         end else if (acc_n == 2) begin
            in_valid = 1'b0;
         end
      end
      check_val("b2b_accepts", 32'(acc_n), 32'd2);
      check_val("b2b_results", 32'(res_n), 32'd2);
      check_val("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
